pcpo_acc_bcd: RTL

//  Downstream consumer of the popcount datapath/controller pair. Captures each 5-bit

---
 rtl/pcpo_acc_bcd.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pcpo_acc_bcd.sv
`default_nettype none
// ============================================================================
// Module      : pcpo_acc_bcd
// Description : Accumulates popcount results on pronto rising edges. Converts
//               the saturating total to 5 BCD digits with a sequential
//               double-dabble FSM. Optional macro SEG7_EN adds a registered
//               5-digit active-low 7-segment output.
// Revision    : 1.0
// ============================================================================
module pcpo_acc_bcd #(
  parameter int TOT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       resultado,
  input  logic             pronto,
  input  logic             clear,
  output logic [TOT_W-1:0] total,
  output logic [CNT_W-1:0] amostras,
  output logic             sat,
  output logic [19:0]      bcd,
  output logic             bcd_valid
`ifdef SEG7_EN
  ,
  output logic [34:0]      seg
`endif
);

  localparam int              c_CNT_B     = $clog2(TOT_W);
  localparam logic [c_CNT_B-1:0] c_SHIFT_LAST = c_CNT_B'(TOT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_pronto_d;
  logic                r_pend;
  logic [TOT_W-1:0]    r_total;
  logic [CNT_W-1:0]    r_amostras;
  logic                r_sat;
  logic [TOT_W-1:0]    r_bin;
  logic [19:0]         r_scratch;
  logic [c_CNT_B-1:0]  r_cnt;
  logic [19:0]         r_bcd;
  logic                r_bcd_valid;
  logic                w_cap;
  logic                w_consume;
  logic [TOT_W:0]      w_sum;
  logic [19:0]         w_adj;

  assign w_cap     = pronto & ~r_pronto_d;
  assign w_sum     = {1'b0, r_total} + {{(TOT_W-4){1'b0}}, resultado};
  // IDLE picks up a pending request; LOAD then samples the freshest total.
  assign w_consume = (r_state == S_IDLE) && r_pend;

  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < 5; i++) begin
      if (r_scratch[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Pronto history starts high so a level already present at reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pronto_d <= 1'b1;
    end else begin
      r_pronto_d <= pronto;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_pend) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == c_SHIFT_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total     <= '0;
      r_amostras  <= '0;
      r_sat       <= 1'b0;
      r_pend      <= 1'b0;
      r_bin       <= '0;
      r_scratch   <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b1;
    end else if (clear) begin
      r_total     <= '0;
      r_amostras  <= '0;
      r_sat       <= 1'b0;
      r_pend      <= 1'b0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b1;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_bin     <= r_total;
          r_scratch <= '0;
          r_cnt     <= '0;
        end
        S_SHIFT: begin
          {r_scratch, r_bin} <= {w_adj[18:0], r_bin, 1'b0};
          r_cnt              <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_bcd       <= r_scratch;
          r_bcd_valid <= ~r_pend;
        end
        default: ;
      endcase

      if (w_consume) begin
        r_pend <= 1'b0;
      end

      if (w_cap) begin
        r_total     <= w_sum[TOT_W] ? {TOT_W{1'b1}} : w_sum[TOT_W-1:0];
        r_sat       <= r_sat | w_sum[TOT_W];
        r_bcd_valid <= 1'b0;
        if (r_amostras != {CNT_W{1'b1}}) begin
          r_amostras <= r_amostras + 1'b1;
        end
        if (!w_consume) begin
          r_pend <= 1'b1;
        end
      end
    end
  end

  assign total     = r_total;
  assign amostras  = r_amostras;
  assign sat       = r_sat;
  assign bcd       = r_bcd;
  assign bcd_valid = r_bcd_valid;

`ifdef SEG7_EN
  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    logic [6:0] v;
    case (d)
      4'd0:    v = 7'h40;
      4'd1:    v = 7'h79;
      4'd2:    v = 7'h24;
      4'd3:    v = 7'h30;
      4'd4:    v = 7'h19;
      4'd5:    v = 7'h12;
      4'd6:    v = 7'h02;
      4'd7:    v = 7'h78;
      4'd8:    v = 7'h00;
      4'd9:    v = 7'h10;
      default: v = 7'h7F;
    endcase
    return v;
  endfunction

  logic [34:0] w_seg;
  logic [34:0] r_seg;

  for (genvar gi = 0; gi < 5; gi++) begin : g_seg
    assign w_seg[gi*7 +: 7] = f_seg7(r_bcd[gi*4 +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= {5{7'h40}};
    end else begin
      r_seg <= w_seg;
    end
  end

  assign seg = r_seg;
`endif

endmodule
`default_nettype wire
